// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between ifetch and decode
//
// Purpose: DEPTH-entry first-word fall-through FIFO that lets fetch run ahead
// of decode. Each entry carries instruction, address, predicted next address,
// and fetch exception flag/cause. Once a faulting fetch is queued, the queue
// stops accepting fetches until flush or rst.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               empties the queue next cycle, clears the exception lock
//   prev_stalled        upstream entry not valid
//   stall_prev          queue cannot accept (full or exception lock)
//   in_*                upstream entry fields
//   next_stalled        decode not ready
//   stall_next          queue has no valid output (empty)
//   out_*               head entry fields (don't-care while empty)
//   count               number of occupied entries
module fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int ILEN    = 32,
   parameter int ALEN    = 32,
   parameter int CAUSE_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       prev_stalled,
   output logic                       stall_prev,
   input  logic [ILEN-1:0]            in_instruction,
   input  logic [ALEN-1:0]            in_addr,
   input  logic [ALEN-1:0]            in_next_addr,
   input  logic                       in_exception,
   input  logic [CAUSE_W-1:0]         in_trap_cause,
   input  logic                       next_stalled,
   output logic                       stall_next,
   output logic [ILEN-1:0]            out_instruction,
   output logic [ALEN-1:0]            out_addr,
   output logic [ALEN-1:0]            out_next_addr,
   output logic                       out_exception,
   output logic [CAUSE_W-1:0]         out_trap_cause,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [ILEN-1:0]    instr_mem [DEPTH];
   logic [ALEN-1:0]    addr_mem  [DEPTH];
   logic [ALEN-1:0]    next_mem  [DEPTH];
   logic               exc_mem   [DEPTH];
   logic [CAUSE_W-1:0] cause_mem [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          exc_lock;
   logic          push;
   logic          pop;

   // Both stall outputs come from registered state only, so neither handshake
   // side sees a combinational path through the queue.
   assign stall_prev = (count == CW'(DEPTH)) || exc_lock;
   assign stall_next = (count == '0);

   // A handshake coinciding with flush/rst is discarded, including its write.
   assign push = !prev_stalled && !stall_prev && !flush && !rst;
   assign pop  = !stall_next && !next_stalled && !flush && !rst;

   assign out_instruction = instr_mem[rd_ptr];
   assign out_addr        = addr_mem[rd_ptr];
   assign out_next_addr   = next_mem[rd_ptr];
   assign out_exception   = exc_mem[rd_ptr];
   assign out_trap_cause  = cause_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= in_instruction;
         addr_mem[wr_ptr]  <= in_addr;
         next_mem[wr_ptr]  <= in_next_addr;
         exc_mem[wr_ptr]   <= in_exception;
         cause_mem[wr_ptr] <= in_trap_cause;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         exc_lock <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            // Lock stays set after the faulting entry drains; only flush/rst
            // release it, since the pipeline is about to be redirected anyway.
            if (in_exception) exc_lock <= 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
